qu_uop_queue: RTL

Parametrised multi-lane micro-op queue between rename/dispatch and issue in the Qu pipeline. Holds packed `qu_uop::uop_t` words of UOP_WIDTH bits in a circular buffer. Each cycle it accepts up to ENQ_W uops and presents the DEQ_W oldest to issue. Supports all-lane flush on branch mispredict.

---
 rtl/qu_uop_queue_if.sv | 39 +++
 rtl/qu_uop_queue.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/qu_uop_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : qu_uop_queue_if
//  Description : Handshake / data bundle for the Qu micro-op queue. The
//                master modport is the rename/dispatch + issue side; the
//                slave modport is the queue itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface qu_uop_queue_if #(
   parameter int UOP_W = 83,
   parameter int DEPTH = 16,
   parameter int ENQ_W = 2,
   parameter int DEQ_W = 2
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DC_W  = $clog2(DEQ_W + 1);

   logic                     flush_i;
   logic [ENQ_W-1:0]         enq_valid_i;
   logic [ENQ_W*UOP_W-1:0]   enq_uop_i;
   logic                     enq_ready_o;
   logic [DEQ_W-1:0]         deq_valid_o;
   logic [DEQ_W*UOP_W-1:0]   deq_uop_o;
   logic [DC_W-1:0]          deq_count_i;
   logic [CNT_W-1:0]         count_o;
   logic                     empty_o;
   logic                     full_o;

   modport master (
      output flush_i, enq_valid_i, enq_uop_i, deq_count_i,
      input  enq_ready_o, deq_valid_o, deq_uop_o, count_o, empty_o, full_o
   );

   modport slave (
      input  flush_i, enq_valid_i, enq_uop_i, deq_count_i,
      output enq_ready_o, deq_valid_o, deq_uop_o, count_o, empty_o, full_o
   );
endinterface
`default_nettype wire

// File: rtl/qu_uop_queue.sv
`default_nettype none
// ============================================================================
//  Module      : qu_uop_queue
//  Description : Multi-lane circular micro-op queue between rename/dispatch
//                and issue. Accepts up to ENQ_W contiguous uops per cycle
//                (all-or-nothing, gated by a registered ready), presents the
//                DEQ_W oldest entries, and supports a full flush.
//                Optional macro QU_UOP_QUEUE_PERF_EN adds a saturating
//                enqueue-stall counter and an occupancy high-water mark.
//  Revision    : 1.0 - initial release
// ============================================================================
module qu_uop_queue #(
   parameter int UOP_W = 83,
   parameter int DEPTH = 16,
   parameter int ENQ_W = 2,
   parameter int DEQ_W = 2
) (
   input  wire logic                          clk,
   input  wire logic                          rstn,
   qu_uop_queue_if.slave                      q_if
`ifdef QU_UOP_QUEUE_PERF_EN
   ,
   output logic [31:0]                        perf_full_cycles_o,
   output logic [$clog2(DEPTH+1)-1:0]         perf_max_occ_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_ENQ_W = CNT_W'(ENQ_W);

   // Storage is deliberately left without reset; validity comes from count.
   logic [UOP_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             enq_ready_q, enq_ready_d;

   logic [CNT_W-1:0] w_n_enq;
   logic [CNT_W-1:0] w_n_deq;
   logic [CNT_W-1:0] w_deq_req;
   logic             w_run;

   // Count contiguous valid lanes from lane 0; nothing is taken when not ready.
   always_comb begin
      w_n_enq = '0;
      w_run   = 1'b1;
      for (int i = 0; i < ENQ_W; i++) begin
         if (w_run && q_if.enq_valid_i[i]) begin
            w_n_enq = w_n_enq + CNT_W'(1);
         end else begin
            w_run = 1'b0;
         end
      end
      if (!enq_ready_q) begin
         w_n_enq = '0;
      end
   end

   // Clamp the consumer's dequeue request to the current occupancy.
   always_comb begin
      w_deq_req = CNT_W'(q_if.deq_count_i);
      w_n_deq   = (w_deq_req > count_q) ? count_q : w_deq_req;
   end

   // Next-state pointers, occupancy and ready; flush overrides everything.
   always_comb begin
      head_d      = head_q + PTR_W'(w_n_deq);
      tail_d      = tail_q + PTR_W'(w_n_enq);
      count_d     = count_q + w_n_enq - w_n_deq;
      enq_ready_d = ((c_DEPTH - count_d) >= c_ENQ_W);
      if (q_if.flush_i) begin
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         enq_ready_d = 1'b0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         enq_ready_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         enq_ready_q <= enq_ready_d;
      end
   end

   // Write accepted lanes at tail, tail+1, ... (pointer wraps naturally).
   always_ff @(posedge clk) begin
      for (int i = 0; i < ENQ_W; i++) begin
         if (!q_if.flush_i && (CNT_W'(i) < w_n_enq)) begin
            mem_q[tail_q + PTR_W'(i)] <= q_if.enq_uop_i[i*UOP_W +: UOP_W];
         end
      end
   end

   // Present the oldest entries; lanes beyond occupancy read as zero.
   for (genvar g = 0; g < DEQ_W; g++) begin : g_deq
      assign q_if.deq_valid_o[g] = (count_q > CNT_W'(g));
      assign q_if.deq_uop_o[g*UOP_W +: UOP_W] =
         q_if.deq_valid_o[g] ? mem_q[head_q + PTR_W'(g)] : '0;
   end

   assign q_if.enq_ready_o = enq_ready_q;
   assign q_if.count_o     = count_q;
   assign q_if.empty_o     = (count_q == '0);
   assign q_if.full_o      = (count_q == c_DEPTH);

`ifdef QU_UOP_QUEUE_PERF_EN
   logic [31:0]      perf_stall_q;
   logic [CNT_W-1:0] perf_max_q;

   // Stall cycles (lane 0 offered while not ready) and occupancy high-water
   // mark; only reset clears them, flush does not.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_stall_q <= '0;
         perf_max_q   <= '0;
      end else begin
         if (q_if.enq_valid_i[0] && !enq_ready_q && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (count_d > perf_max_q) begin
            perf_max_q <= count_d;
         end
      end
   end

   assign perf_full_cycles_o = perf_stall_q;
   assign perf_max_occ_o     = perf_max_q;
`endif

`ifndef SYNTHESIS
   a_deq_count_le_occ : assert property (@(posedge clk) disable iff (!rstn)
      (CNT_W'(q_if.deq_count_i) <= count_q))
      else $error("qu_uop_queue: deq_count_i exceeds occupancy");
`endif

endmodule
`default_nettype wire
